trace_line_packer: RTL and testbench
====================================

Name: trace_line_packer

Overview:
- Streaming successor to the trace formatter: accepts one trace word per handshake and packs WORDS_PER_LINE words into one cache line.
- Supports a flush command that emits a partial line, zero-padded.
- Sits between the trace source (memory/ROM reader) and the compressor / uncompressed-dump stage.
- Width, depth and slot ordering are parametrised; both sides use valid/ready back-pressure.

Parameters:
- WORD_W, 32, width of one trace word.
- WORDS_PER_LINE, 8, words per cache line. Must be a power of two and ≥2. LINE_W = WORD_W*WORDS_PER_LINE.
- FIRST_WORD_MSB, 1, slot ordering. 1: slot k is out_line[LINE_W-1-k*WORD_W -: WORD_W]. 0: slot k is out_line[k*WORD_W +: WORD_W].
- CNT_W, 16, width of line_count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data valid
- in_ready  out  1  packer can accept a word this cycle
- in_data  in  WORD_W  trace word
- flush  in  1  single-cycle request to emit the current partial line
- out_valid  out  1  out_line holds a line
- out_ready  in  1  downstream accepts the line
- out_line  out  LINE_W  packed line
- out_words  out  $clog2(WORDS_PER_LINE)+1  number of valid slots in out_line (1..WORDS_PER_LINE)
- line_count  out  CNT_W  lines delivered since reset, saturating
- busy  out  1  fill count nonzero, or out_valid, or a flush is pending

Behaviour:
- Reset (async assert, sync release): acc=0, fill=0, flush_pend=0, out_valid=0, out_line=0, out_words=0, line_count=0, busy=0.
- Word accept: in_valid && in_ready. The k-th word since the last emission (k=fill) is written into acc slot k; fill increments.
- Output register free (out_free) = !out_valid || out_ready.
- in_ready = !flush_pend && (fill != WORDS_PER_LINE-1 || out_free).
  - This is a combinational path from out_ready. No other combinational input-to-output paths are allowed.
- Full-line emit: accepting word WORDS_PER_LINE-1 loads {acc with that word} into out_line on the same edge.
  - out_valid=1, out_words=WORDS_PER_LINE, acc cleared, fill=0.
  - Latency: line visible the cycle after the last word is accepted.
- Flush sampled high:
  - Effective count c = fill + (word accepted same cycle).
  - c==0: no-op. Nothing emitted, no pending flag set.
  - c>0 and out_free: emit acc (including the same-cycle word) with unused slots zero and out_words=c; fill=0, acc=0.
  - c>0 and !out_free: set flush_pend, and in_ready drops next cycle. The emit occurs on the first edge where out_free; flush_pend then clears.
  - Flush on the same cycle as the Nth word: a normal full line is emitted. The flush is absorbed because c is then 0 for the remainder.
  - Further flush pulses while flush_pend=1 are ignored.
- Output handshake: out_valid && out_ready.
  - line_count increments, saturating at 2^CNT_W-1.
  - out_valid clears unless a new line loads on the same edge (back-to-back permitted).
- Stability: while out_valid && !out_ready, out_line and out_words hold constant.
- Unused slots and the whole of out_line outside valid slots are always zero.
- Mid-operation reset: partial acc contents and any undelivered line are discarded. No emission after reset release.

Test Plan:
- Defaults; feed 0x00000001..0x00000008 with out_ready=1.
  - Expect one line 0x00000001_00000002_…_00000008, out_words=8, line_count=1, in_ready never low.
- FIRST_WORD_MSB=0; same stimulus.
  - Expect out_line = 0x00000008_…_00000001.
- Feed 0xA,0xB,0xC then a flush pulse.
  - Expect 0x0000000A_0000000B_0000000C_00000000…, out_words=3, fill back to 0.
- Hold out_ready=0 with a line pending; feed 7 more words.
  - in_ready goes low at the 8th word. Raise out_ready: first line delivered, then the second line appears next cycle. line_count=2; out_line stays stable while stalled.
- Flush while stalled with fill=2.
  - flush_pend=1, in_ready=0. On out_ready, two lines are delivered in order, the second with out_words=2. Then: a flush with fill=0 produces nothing; a flush coincident with the 8th word produces a single full line.
- Assert rst_n=0 mid-line (fill=5, out_valid=1).
  - All outputs zero immediately (async). After release, the next 8 words form a clean line with line_count=1.

Source files
------------

// File: rtl/trace_line_packer.sv
// ============================================================================
// Module   : trace_line_packer
// Purpose  : Packs a stream of trace words into cache lines; a flush emits a
//            zero-padded partial line. Valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_line_packer #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter bit FIRST_WORD_MSB = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WORD_W-1:0]                   in_data,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_W*WORDS_PER_LINE-1:0]    out_line,
  output logic [$clog2(WORDS_PER_LINE):0]     out_words,
  output logic [CNT_W-1:0]                    line_count,
  output logic                                busy
);

  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int FILL_W = $clog2(WORDS_PER_LINE);
  localparam int WCNT_W = FILL_W + 1;
  localparam logic [FILL_W-1:0] c_LAST_SLOT = FILL_W'(WORDS_PER_LINE - 1);

  logic [LINE_W-1:0] acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              flush_pend_q, flush_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [LINE_W-1:0] out_line_q, out_line_d;
  logic [WCNT_W-1:0] out_words_q, out_words_d;
  logic [CNT_W-1:0]  line_count_q, line_count_d;

  logic              w_out_free;
  logic              w_accept;
  logic              w_out_hs;
  logic [LINE_W-1:0] w_acc_wr;
  logic [WCNT_W-1:0] w_cnt;
  logic              w_full_emit;
  logic              w_flush_req;
  logic              w_emit;

  assign w_out_free = !out_valid_q || out_ready;
  assign in_ready   = !flush_pend_q && ((fill_q != c_LAST_SLOT) || w_out_free);
  assign w_accept   = in_valid && in_ready;
  assign w_out_hs   = out_valid_q && out_ready;

  // Accumulator with the current word merged into slot fill_q.
  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_slot
    localparam int BASE = FIRST_WORD_MSB ? (WORDS_PER_LINE - 1 - k) * WORD_W : k * WORD_W;
    assign w_acc_wr[BASE +: WORD_W] = (w_accept && (fill_q == FILL_W'(k)))
                                      ? in_data : acc_q[BASE +: WORD_W];
  end

  assign w_cnt       = {1'b0, fill_q} + WCNT_W'(w_accept);
  assign w_full_emit = w_accept && (fill_q == c_LAST_SLOT);
  // A flush coinciding with the last word is absorbed by the full-line emit.
  assign w_flush_req = flush && !flush_pend_q && !w_full_emit && (w_cnt != '0);
  assign w_emit      = w_full_emit || ((w_flush_req || flush_pend_q) && w_out_free);

  always_comb begin
    acc_d        = w_acc_wr;
    fill_d       = w_cnt[FILL_W-1:0];
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_line_d   = out_line_q;
    out_words_d  = out_words_q;
    line_count_d = line_count_q;

    if (w_flush_req && !w_out_free) begin
      flush_pend_d = 1'b1;
    end

    if (w_emit) begin
      acc_d        = '0;
      fill_d       = '0;
      flush_pend_d = 1'b0;
      out_valid_d  = 1'b1;
      out_line_d   = w_acc_wr;
      out_words_d  = w_cnt;
    end else if (w_out_hs) begin
      out_valid_d  = 1'b0;
      out_line_d   = '0;
      out_words_d  = '0;
    end

    if (w_out_hs && (line_count_q != {CNT_W{1'b1}})) begin
      line_count_d = line_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_line_q   <= '0;
      out_words_q  <= '0;
      line_count_q <= '0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_line_q   <= out_line_d;
      out_words_q  <= out_words_d;
      line_count_q <= line_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_line   = out_line_q;
  assign out_words  = out_words_q;
  assign line_count = line_count_q;
  assign busy       = (fill_q != '0) || out_valid_q || flush_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_line_packer.sv
// ============================================================================
// Module   : tb_trace_line_packer
// Purpose  : Directed self-checking bench for trace_line_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_line_packer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         flush;
  logic         out_ready;

  logic         in_ready_a,  in_ready_b;
  logic         out_valid_a, out_valid_b;
  logic [255:0] out_line_a,  out_line_b;
  logic [3:0]   out_words_a, out_words_b;
  logic [15:0]  line_count_a, line_count_b;
  logic         busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  trace_line_packer #(.WORD_W(32), .WORDS_PER_LINE(8), .FIRST_WORD_MSB(1'b1), .CNT_W(16)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready), .out_line(out_line_a),
    .out_words(out_words_a), .line_count(line_count_a), .busy(busy_a)
  );

  trace_line_packer #(.WORD_W(32), .WORDS_PER_LINE(8), .FIRST_WORD_MSB(1'b0), .CNT_W(16)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready), .out_line(out_line_b),
    .out_words(out_words_b), .line_count(line_count_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send_word(input logic [31:0] d);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    waited = 0;
    while (!in_ready_a && waited < 20) begin
      cyc();
      waited++;
    end
    if (waited >= 20) check_eq("accept_timeout", 256'(in_ready_a), 256'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    logic       ready_seen_low;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Reset state
    check_eq("rst_out_valid",  256'(out_valid_a),  256'd0);
    check_eq("rst_out_line",   out_line_a,         256'd0);
    check_eq("rst_out_words",  256'(out_words_a),  256'd0);
    check_eq("rst_line_count", 256'(line_count_a), 256'd0);
    check_eq("rst_busy",       256'(busy_a),       256'd0);
    check_eq("rst_in_ready",   256'(in_ready_a),   256'd1);

    // Full line, both slot orderings
    ready_seen_low = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      #1;
      if (!in_ready_a) ready_seen_low = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    check_eq("t1_in_ready_never_low", 256'(ready_seen_low), 256'd0);
    check_eq("t1_out_valid", 256'(out_valid_a), 256'd1);
    check_eq("t1_line_msb", out_line_a,
      256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    check_eq("t1_line_lsb", out_line_b,
      256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    check_eq("t1_out_words", 256'(out_words_a), 256'd8);
    cyc();
    check_eq("t1_line_count", 256'(line_count_a), 256'd1);
    check_eq("t1_valid_clear", 256'(out_valid_a), 256'd0);

    // Partial line via flush
    send_word(32'hA);
    send_word(32'hB);
    send_word(32'hC);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("t3_out_valid", 256'(out_valid_a), 256'd1);
    check_eq("t3_line", out_line_a,
      256'h0000000A_0000000B_0000000C_00000000_00000000_00000000_00000000_00000000);
    check_eq("t3_out_words", 256'(out_words_a), 256'd3);
    cyc();
    check_eq("t3_busy_idle", 256'(busy_a), 256'd0);
    check_eq("t3_line_count", 256'(line_count_a), 256'd2);

    // Back-pressure with a second line queued behind the first
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(32'h11 + 32'(i));
    for (int i = 0; i < 7; i++) send_word(32'h21 + 32'(i));
    in_valid = 1'b1;
    in_data  = 32'h28;
    #1;
    check_eq("t4_in_ready_low", 256'(in_ready_a), 256'd0);
    cyc();
    cyc();
    check_eq("t4_stall_line", out_line_a,
      256'h00000011_00000012_00000013_00000014_00000015_00000016_00000017_00000018);
    check_eq("t4_stall_words", 256'(out_words_a), 256'd8);
    out_ready = 1'b1;
    #1;
    check_eq("t4_in_ready_comb", 256'(in_ready_a), 256'd1);
    cyc();
    in_valid = 1'b0;
    check_eq("t4_b2b_valid", 256'(out_valid_a), 256'd1);
    check_eq("t4_second_line", out_line_a,
      256'h00000021_00000022_00000023_00000024_00000025_00000026_00000027_00000028);
    check_eq("t4_count_first", 256'(line_count_a), 256'd3);
    cyc();
    check_eq("t4_count_second", 256'(line_count_a), 256'd4);

    // Flush while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(32'h31 + 32'(i));
    send_word(32'h41);
    send_word(32'h42);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("t5_pend_in_ready", 256'(in_ready_a), 256'd0);
    check_eq("t5_pend_busy", 256'(busy_a), 256'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("t5_stall_line", out_line_a,
      256'h00000031_00000032_00000033_00000034_00000035_00000036_00000037_00000038);
    out_ready = 1'b1;
    cyc();
    check_eq("t5_partial_line", out_line_a,
      256'h00000041_00000042_00000000_00000000_00000000_00000000_00000000_00000000);
    check_eq("t5_partial_words", 256'(out_words_a), 256'd2);
    check_eq("t5_count_first", 256'(line_count_a), 256'd5);
    check_eq("t5_in_ready_back", 256'(in_ready_a), 256'd1);
    cyc();
    check_eq("t5_count_second", 256'(line_count_a), 256'd6);
    check_eq("t5_drained", 256'(out_valid_a), 256'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("t5_empty_flush", 256'(out_valid_a), 256'd0);
    check_eq("t5_empty_busy", 256'(busy_a), 256'd0);
    for (int i = 0; i < 7; i++) send_word(32'h51 + 32'(i));
    in_valid = 1'b1;
    in_data  = 32'h58;
    flush    = 1'b1;
    cyc();
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("t5_coinc_words", 256'(out_words_a), 256'd8);
    check_eq("t5_coinc_line", out_line_a,
      256'h00000051_00000052_00000053_00000054_00000055_00000056_00000057_00000058);
    cyc();
    check_eq("t5_coinc_count", 256'(line_count_a), 256'd7);
    cyc();
    check_eq("t5_coinc_single", 256'(out_valid_a), 256'd0);

    // Asynchronous reset mid-line
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(32'h61 + 32'(i));
    for (int i = 0; i < 5; i++) send_word(32'h71 + 32'(i));
    check_eq("t6_pre_busy", 256'(busy_a), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 256'(out_valid_a), 256'd0);
    check_eq("t6_rst_line",  out_line_a,        256'd0);
    check_eq("t6_rst_words", 256'(out_words_a), 256'd0);
    check_eq("t6_rst_count", 256'(line_count_a), 256'd0);
    check_eq("t6_rst_busy",  256'(busy_a),      256'd0);
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc();
    check_eq("t6_no_emit", 256'(out_valid_a), 256'd0);
    for (int i = 0; i < 8; i++) send_word(32'h81 + 32'(i));
    check_eq("t6_clean_line", out_line_a,
      256'h00000081_00000082_00000083_00000084_00000085_00000086_00000087_00000088);
    cyc();
    check_eq("t6_count", 256'(line_count_a), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
